time_counter: RTL and testbench

BCD time-of-day counter that generates the six digits (hour tens/ones, minute tens/ones, second tens/ones) consumed by the downstream time register. A parameterised prescaler derives a one-second tick from `clk`. The block advances the time while enabled, accepts a validated parallel time load for setting the clock, and flags the midnight rollover.

---
 rtl/time_counter.sv | 139 +++++++++++++
 tb/tb_time_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// BCD time-of-day counter with a one-second prescaler, validated parallel load and midnight pulse.
// Define TWELVE_HOUR_EN for 12-hour mode with AM/PM flag; the default build counts 00..23.
module time_counter #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [3:0] ht_in,
  input  logic [3:0] ho_in,
  input  logic [3:0] mt_in,
  input  logic [3:0] mo_in,
  input  logic [3:0] st_in,
  input  logic [3:0] so_in,
  input  logic       pm_in,
  output logic [3:0] ht,
  output logic [3:0] ho,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_pulse,
  output logic       load_err
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_SEC - 1);

  typedef struct packed {
    logic [3:0] ht, ho, mt, mo, st, so;
    logic       pm;
  } tod_t;

`ifdef TWELVE_HOUR_EN
  localparam tod_t RST = tod_t'({4'd1, 4'd2, 16'd0, 1'b0});
`else
  localparam tod_t RST = '0;
`endif

  logic [PW-1:0] pcnt;
  tod_t          cur, nxt, ld;
  logic          wrap, min_c, hr_c, hr_ok, ld_ok;

`ifdef TWELVE_HOUR_EN
  assign ld    = '{ht: ht_in, ho: ho_in, mt: mt_in, mo: mo_in, st: st_in, so: so_in, pm: pm_in};
  assign hr_ok = (ht_in == 4'd0 && ho_in >= 4'd1 && ho_in <= 4'd9) ||
                 (ht_in == 4'd1 && ho_in <= 4'd2);
`else
  logic unused_pm_in;
  assign unused_pm_in = pm_in;
  assign ld    = '{ht: ht_in, ho: ho_in, mt: mt_in, mo: mo_in, st: st_in, so: so_in, pm: 1'b0};
  assign hr_ok = (ht_in <= 4'd1 && ho_in <= 4'd9) || (ht_in == 4'd2 && ho_in <= 4'd3);
`endif

  assign ld_ok = hr_ok && (mt_in <= 4'd5) && (mo_in <= 4'd9) &&
                 (st_in <= 4'd5) && (so_in <= 4'd9);

  assign min_c = (cur.st == 4'd5) && (cur.so == 4'd9);
  assign hr_c  = min_c && (cur.mt == 4'd5) && (cur.mo == 4'd9);

  // Next time for an advance: ripple carry through the BCD digits.
  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    nxt.so = (cur.so == 4'd9) ? 4'd0 : cur.so + 4'd1;
    if (cur.so == 4'd9) nxt.st = (cur.st == 4'd5) ? 4'd0 : cur.st + 4'd1;
    if (min_c)          nxt.mo = (cur.mo == 4'd9) ? 4'd0 : cur.mo + 4'd1;
    if (min_c && cur.mo == 4'd9) nxt.mt = (cur.mt == 4'd5) ? 4'd0 : cur.mt + 4'd1;
    if (hr_c) begin
`ifdef TWELVE_HOUR_EN
      if (cur.ht == 4'd1 && cur.ho == 4'd2) begin
        nxt.ht = 4'd0;
        nxt.ho = 4'd1;
      end else if (cur.ht == 4'd1 && cur.ho == 4'd1) begin
        // 11:59:59 -> 12:00:00 flips AM/PM; PM->AM is midnight.
        nxt.ho = 4'd2;
        nxt.pm = ~cur.pm;
        wrap   = cur.pm;
      end else if (cur.ho == 4'd9) begin
        nxt.ht = 4'd1;
        nxt.ho = 4'd0;
      end else begin
        nxt.ho = cur.ho + 4'd1;
      end
`else
      if (cur.ht == 4'd2 && cur.ho == 4'd3) begin
        nxt.ht = 4'd0;
        nxt.ho = 4'd0;
        wrap   = 1'b1;
      end else if (cur.ho == 4'd9) begin
        nxt.ht = cur.ht + 4'd1;
        nxt.ho = 4'd0;
      end else begin
        nxt.ho = cur.ho + 4'd1;
      end
`endif
    end
  end

  // A valid load takes priority over an advance; a rejected one does not block it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= RST;
      pcnt      <= '0;
      sec_tick  <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_err  <= load && !ld_ok;
      sec_tick  <= 1'b0;
      day_pulse <= 1'b0;
      if (load && ld_ok) begin
        cur  <= ld;
        pcnt <= '0;
      end else if (run) begin
        if (pcnt == PMAX) begin
          pcnt      <= '0;
          cur       <= nxt;
          sec_tick  <= 1'b1;
          day_pulse <= wrap;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

  assign ht = cur.ht;
  assign ho = cur.ho;
  assign mt = cur.mt;
  assign mo = cur.mo;
  assign st = cur.st;
  assign so = cur.so;
  assign pm = cur.pm;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench: seconds-of-day reference model compared every cycle, plus literal scenarios.
module tb_time_counter;
  localparam int N = 4;

  logic       clk = 1'b0, reset = 1'b0, run = 1'b0, load = 1'b0, pm_in = 1'b0;
  logic [3:0] ht_in = '0, ho_in = '0, mt_in = '0, mo_in = '0, st_in = '0, so_in = '0;
  logic [3:0] ht, ho, mt, mo, st, so;
  logic       pm, sec_tick, day_pulse, load_err;

  time_counter #(.CLKS_PER_SEC(N)) dut (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .ht_in(ht_in), .ho_in(ho_in), .mt_in(mt_in), .mo_in(mo_in), .st_in(st_in), .so_in(so_in),
    .pm_in(pm_in),
    .ht(ht), .ho(ho), .mt(mt), .mo(mo), .st(st), .so(so), .pm(pm),
    .sec_tick(sec_tick), .day_pulse(day_pulse), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds since midnight, prescaler as plain integer.
  int m_tod = 0, m_pcnt = 0;
  bit m_tick = 0, m_day = 0, m_err = 0, m_valid;

  function automatic bit load_valid();
    int h;
    h = int'(ht_in) * 10 + int'(ho_in);
    if (so_in > 9 || mo_in > 9 || ho_in > 9 || st_in > 5 || mt_in > 5) return 1'b0;
`ifdef TWELVE_HOUR_EN
    return (h >= 1 && h <= 12);
`else
    return (h <= 23);
`endif
  endfunction

  function automatic int load_tod();
    int h;
    h = int'(ht_in) * 10 + int'(ho_in);
`ifdef TWELVE_HOUR_EN
    h = (h % 12) + (pm_in ? 12 : 0);
`endif
    return h * 3600 + (int'(mt_in) * 10 + int'(mo_in)) * 60 + int'(st_in) * 10 + int'(so_in);
  endfunction

  always @(posedge clk) begin
    int h24, eh, mm, ss;
    bit epm;
    if (!reset) begin
      m_tod = 0; m_pcnt = 0; m_tick = 0; m_day = 0; m_err = 0;
    end else begin
      m_valid = load && load_valid();
      m_err   = load && !m_valid;
      m_tick  = 0;
      m_day   = 0;
      if (m_valid) begin
        m_tod  = load_tod();
        m_pcnt = 0;
      end else if (run) begin
        if (m_pcnt == N - 1) begin
          m_pcnt = 0;
          m_tod  = (m_tod + 1) % 86400;
          m_tick = 1;
          m_day  = (m_tod == 0);
        end else begin
          m_pcnt++;
        end
      end
    end
    h24 = m_tod / 3600;
    mm  = (m_tod / 60) % 60;
    ss  = m_tod % 60;
`ifdef TWELVE_HOUR_EN
    epm = (h24 >= 12);
    eh  = (h24 % 12 == 0) ? 12 : h24 % 12;
`else
    epm = 0;
    eh  = h24;
`endif
    #1;
    chk("m_ht", 32'(ht), 32'(eh / 10));
    chk("m_ho", 32'(ho), 32'(eh % 10));
    chk("m_mt", 32'(mt), 32'(mm / 10));
    chk("m_mo", 32'(mo), 32'(mm % 10));
    chk("m_st", 32'(st), 32'(ss / 10));
    chk("m_so", 32'(so), 32'(ss % 10));
    chk("m_pm", 32'(pm), 32'(epm));
    chk("m_tick", 32'(sec_tick), 32'(m_tick));
    chk("m_day", 32'(day_pulse), 32'(m_day));
    chk("m_err", 32'(load_err), 32'(m_err));
  end

  task automatic do_load(input int a, b, c, d, e, f, input bit p);
    ht_in = 4'(a); ho_in = 4'(b); mt_in = 4'(c); mo_in = 4'(d); st_in = 4'(e); so_in = 4'(f);
    pm_in = p;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b1;
    wait_neg(3);
    chk("rst_mt", 32'(mt), 0);
    chk("rst_so", 32'(so), 0);
    chk("rst_tick", 32'(sec_tick), 0);
    reset = 1'b1;
    wait_neg(4);
    chk("first_so", 32'(so), 1);
    chk("first_tick", 32'(sec_tick), 1);

    // asynchronous reset mid-count
    wait_neg(2);
    #2 reset = 1'b0;
    #1;
    chk("arst_so", 32'(so), 0);
    chk("arst_tick", 32'(sec_tick), 0);
    chk("arst_day", 32'(day_pulse), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifndef TWELVE_HOUR_EN
    do_load(2, 3, 5, 9, 5, 9, 0);
    wait_neg(4);
    chk("mid_ht", 32'(ht), 0);
    chk("mid_ho", 32'(ho), 0);
    chk("mid_so", 32'(so), 0);
    chk("mid_tick", 32'(sec_tick), 1);
    chk("mid_day", 32'(day_pulse), 1);
    @(negedge clk);
    chk("mid_day_off", 32'(day_pulse), 0);

    do_load(1, 2, 6, 0, 0, 0, 0);
    chk("bad_err", 32'(load_err), 1);
    chk("bad_ho", 32'(ho), 0);
    @(negedge clk);
    chk("bad_err_off", 32'(load_err), 0);
    @(negedge clk);
    chk("bad_adv_so", 32'(so), 1);
    chk("bad_adv_tick", 32'(sec_tick), 1);

    do_load(0, 1, 0, 2, 0, 3, 0);
    wait_neg(3);
    do_load(0, 8, 1, 5, 3, 0, 0);
    chk("coin_ho", 32'(ho), 8);
    chk("coin_mo", 32'(mo), 5);
    chk("coin_so", 32'(so), 0);
    chk("coin_tick", 32'(sec_tick), 0);
    wait_neg(4);
    chk("coin_next_so", 32'(so), 1);
    chk("coin_next_tick", 32'(sec_tick), 1);

    wait_neg(2);
    run = 1'b0;
    wait_neg(10);
    chk("hold_so", 32'(so), 1);
    run = 1'b1;
    @(negedge clk);
    chk("resume_so", 32'(so), 1);
    @(negedge clk);
    chk("resume_adv_so", 32'(so), 2);
    chk("resume_tick", 32'(sec_tick), 1);
`else
    do_load(1, 1, 5, 9, 5, 9, 0);
    wait_neg(4);
    chk("noon_ht", 32'(ht), 1);
    chk("noon_ho", 32'(ho), 2);
    chk("noon_pm", 32'(pm), 1);
    chk("noon_day", 32'(day_pulse), 0);
    do_load(1, 2, 5, 9, 5, 9, 1);
    wait_neg(4);
    chk("one_ho", 32'(ho), 1);
    chk("one_pm", 32'(pm), 1);
    do_load(1, 1, 5, 9, 5, 9, 1);
    wait_neg(4);
    chk("mn_ho", 32'(ho), 2);
    chk("mn_pm", 32'(pm), 0);
    chk("mn_day", 32'(day_pulse), 1);
    do_load(1, 3, 0, 0, 0, 0, 0);
    chk("bad13_err", 32'(load_err), 1);
`endif

    // randomized phase: run toggling, sparse loads (some invalid, many near rollover), rare resets
    for (int i = 0; i < 3000; i++) begin
      run   = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 499) != 0);
      load  = 1'b0;
      if ($urandom_range(0, 14) == 0) begin
        int h, k;
        k = $urandom_range(0, 3);
`ifdef TWELVE_HOUR_EN
        h = $urandom_range(1, 12);
`else
        h = $urandom_range(0, 23);
`endif
        ht_in = 4'(h / 10);
        ho_in = 4'(h % 10);
        mt_in = 4'(k == 1 ? 5 : $urandom_range(0, 5));
        mo_in = 4'(k == 1 ? 9 : $urandom_range(0, 9));
        st_in = 4'(k == 1 ? 5 : $urandom_range(0, 5));
        so_in = 4'($urandom_range(5, 9));
        pm_in = 1'($urandom_range(0, 1));
        if (k == 0) begin
          ht_in = 4'($urandom_range(0, 15));
          ho_in = 4'($urandom_range(0, 15));
          mt_in = 4'($urandom_range(0, 15));
          so_in = 4'($urandom_range(0, 15));
        end
        load = 1'b1;
      end
      @(negedge clk);
    end
    load  = 1'b0;
    reset = 1'b1;
    wait_neg(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
